bp_be_branch_resolver: RTL

- Backend-side producer of the frontend's branch-feedback interface.
- Takes resolved control-flow results from the execute pipe and compares each actual next PC with the PC the frontend predicted.
- On a mispredict, issues a one-cycle redirect carrying the branch metadata. On a correct prediction of a control instruction, queues an attaboy so the frontend can train its BTB and BHT.
- Sits between the execute pipe and the frontend's redirect/attaboy inputs.

---
 rtl/bp_be_branch_resolver_pkg.sv | 43 ++++
 rtl/bp_be_branch_resolver_if.sv | 42 ++++
 rtl/bp_be_branch_resolver_attaboy_fifo.sv | 61 ++++++
 rtl/bp_be_branch_resolver.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bp_be_branch_resolver_pkg.sv
// bp_be_pkg: shared types for the backend branch resolver.
// Latency: n/a (types, config helpers and the attaboy entry macro only).
// Backpressure: n/a.
// Contents: processor config enum and width helpers, resolver FSM state enum,
// and a macro that declares the attaboy entry struct for given widths.

// Declares bp_be_attaboy_entry_s in the enclosing scope. It is a macro because
// the field widths come from module parameters, not package constants.
`define BP_BE_ATTABOY_ENTRY_S(vaddr_w, md_w) \
  typedef struct packed { \
    logic [(vaddr_w)-1:0] pc; \
    logic [(md_w)-1:0]    br_metadata_fwd; \
    logic                 taken; \
    logic                 ntaken; \
  } bp_be_attaboy_entry_s

package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg,
    e_bp_small_cfg
  } bp_params_e;

  typedef enum logic [0:0] {
    e_run,
    e_wait
  } bp_be_resolver_state_e;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_small_cfg: return 32;
      default:        return 39;
    endcase
  endfunction

  function automatic int bp_metadata_fwd_width(bp_params_e cfg);
    case (cfg)
      e_bp_small_cfg: return 16;
      default:        return 32;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_branch_resolver_if.sv
// bp_be_branch_resolver_if: backend-to-frontend branch feedback bundle.
// Latency: n/a (wires only); redirect is a pulse, attaboy is a valid/yumi head.
// Backpressure: redirect has none; attaboy is held until the frontend yumis it.
// master = resolver (drives redirect/attaboy/drop count, samples yumi),
// slave  = frontend (samples redirect/attaboy, drives yumi).
interface bp_be_branch_resolver_if #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 32,
  parameter int drop_cnt_width_p            = 16
);
  logic                                   redirect_v_o;
  logic [vaddr_width_p-1:0]               redirect_pc_o;
  logic                                   redirect_br_v_o;
  logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o;
  logic                                   redirect_br_taken_o;
  logic                                   redirect_br_ntaken_o;
  logic                                   redirect_br_nonbr_o;

  logic                                   attaboy_v_o;
  logic [vaddr_width_p-1:0]               attaboy_pc_o;
  logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o;
  logic                                   attaboy_taken_o;
  logic                                   attaboy_ntaken_o;
  logic                                   attaboy_yumi_i;
  logic [drop_cnt_width_p-1:0]            attaboy_drop_cnt_o;

  modport master (
    output redirect_v_o, redirect_pc_o, redirect_br_v_o, redirect_br_metadata_fwd_o,
           redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o,
           attaboy_v_o, attaboy_pc_o, attaboy_br_metadata_fwd_o,
           attaboy_taken_o, attaboy_ntaken_o, attaboy_drop_cnt_o,
    input  attaboy_yumi_i
  );

  modport slave (
    input  redirect_v_o, redirect_pc_o, redirect_br_v_o, redirect_br_metadata_fwd_o,
           redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o,
           attaboy_v_o, attaboy_pc_o, attaboy_br_metadata_fwd_o,
           attaboy_taken_o, attaboy_ntaken_o, attaboy_drop_cnt_o,
    output attaboy_yumi_i
  );
endinterface

// File: rtl/bp_be_branch_resolver_attaboy_fifo.sv
// bp_be_attaboy_fifo: 1r1w queue with wrap-around pointers plus an extra full bit.
// Latency: an entry written in cycle N is at the head in cycle N+1; head is combinational.
// Backpressure: full_o reported; writer pushes only when not full or when yumi pops that cycle.
// Ports: v_i/data_i write; v_o/data_o/yumi_i read (yumi ignored when empty); full_o.
module bp_be_attaboy_fifo #(
  parameter int els_p   = 4,
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = $clog2(els_p);

  logic [ptr_w_lp:0]  wptr_q, wptr_d;
  logic [ptr_w_lp:0]  rptr_q, rptr_d;
  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] mem_d [els_p];
  logic               empty;
  logic               deq;

  // Equal low bits with differing wrap bits means the writer lapped the reader.
  assign empty  = (wptr_q == rptr_q);
  assign full_o = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp])
               && (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);
  assign v_o    = ~empty;
  assign deq    = yumi_i & ~empty;
  assign data_o = v_o ? mem_q[rptr_q[ptr_w_lp-1:0]] : '0;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (v_i) begin
      mem_d[wptr_q[ptr_w_lp-1:0]] = data_i;
      wptr_d = wptr_q + (ptr_w_lp+1)'(1);
    end
    if (deq) begin
      rptr_d = rptr_q + (ptr_w_lp+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < els_p; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end
endmodule

// File: rtl/bp_be_branch_resolver.sv
// bp_be_branch_resolver: compares resolved next PC against the frontend's prediction;
// Latency: 1 cycle from resolution to registered redirect pulse or attaboy at queue head.
// Backpressure: redirect has none; attaboys queue and drop (counted) when the queue is full.
// Ports: clk_i/reset_n_i; ext_redirect_* (trap/CSR/fence redirect); res_* (execute
// resolution); fb_if master (redirect pulse, attaboy valid/yumi head, drop count).
module bp_be_branch_resolver
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p                 = e_bp_default_cfg,
  parameter int         vaddr_width_p               = bp_vaddr_width(bp_params_p),
  parameter int         branch_metadata_fwd_width_p = bp_metadata_fwd_width(bp_params_p),
  parameter int         attaboy_fifo_els_p          = 4,
  parameter int         drop_cnt_width_p            = 16
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   ext_redirect_v_i,
  input  logic [vaddr_width_p-1:0]               ext_redirect_pc_i,
  input  logic                                   res_v_i,
  input  logic [vaddr_width_p-1:0]               res_pc_i,
  input  logic [vaddr_width_p-1:0]               res_npc_pred_i,
  input  logic [vaddr_width_p-1:0]               res_tgt_i,
  input  logic                                   res_taken_i,
  input  logic                                   res_ctrl_i,
  input  logic [branch_metadata_fwd_width_p-1:0] res_br_metadata_fwd_i,
  bp_be_branch_resolver_if.master                fb_if
);

  `BP_BE_ATTABOY_ENTRY_S(vaddr_width_p, branch_metadata_fwd_width_p);

  localparam int entry_width_lp = $bits(bp_be_attaboy_entry_s);

  bp_be_resolver_state_e state_q, state_d;
  logic [vaddr_width_p-1:0] expect_pc_q, expect_pc_d;

  logic                                   redirect_v_q, redirect_v_d;
  logic [vaddr_width_p-1:0]               redirect_pc_q, redirect_pc_d;
  logic                                   redirect_br_v_q, redirect_br_v_d;
  logic [branch_metadata_fwd_width_p-1:0] redirect_md_q, redirect_md_d;
  logic                                   redirect_taken_q, redirect_taken_d;
  logic                                   redirect_ntaken_q, redirect_ntaken_d;
  logic                                   redirect_nonbr_q, redirect_nonbr_d;

  logic [drop_cnt_width_p-1:0] drop_cnt_q, drop_cnt_d;

  logic [vaddr_width_p-1:0] pc_plus4;
  logic [vaddr_width_p-1:0] actual_npc;
  logic                     mispredict;
  logic                     res_accept;
  logic                     enq_attempt;
  logic                     enq_v;
  logic                     fifo_full;
  logic                     fifo_v;
  bp_be_attaboy_entry_s     enq_entry;
  bp_be_attaboy_entry_s     head_entry;
  logic [entry_width_lp-1:0] head_bits;

  // Address arithmetic wraps modulo 2^vaddr_width_p by truncation.
  assign pc_plus4   = res_pc_i + vaddr_width_p'(4);
  assign actual_npc = res_taken_i ? res_tgt_i : pc_plus4;
  assign mispredict = (res_npc_pred_i != actual_npc);

  // While waiting, only the instruction at the redirect target is on the correct path.
  assign res_accept = res_v_i & ((state_q == e_run) | (res_pc_i == expect_pc_q));

  always_comb begin
    state_d           = state_q;
    expect_pc_d       = expect_pc_q;
    redirect_v_d      = 1'b0;
    redirect_pc_d     = '0;
    redirect_br_v_d   = 1'b0;
    redirect_md_d     = '0;
    redirect_taken_d  = 1'b0;
    redirect_ntaken_d = 1'b0;
    redirect_nonbr_d  = 1'b0;
    enq_attempt       = 1'b0;

    if (ext_redirect_v_i) begin
      // External redirect wins; any same-cycle resolution is discarded.
      redirect_v_d  = 1'b1;
      redirect_pc_d = ext_redirect_pc_i;
      expect_pc_d   = ext_redirect_pc_i;
      state_d       = e_wait;
    end else if (res_accept) begin
      if (mispredict) begin
        redirect_v_d    = 1'b1;
        redirect_br_v_d = 1'b1;
        redirect_md_d   = res_br_metadata_fwd_i;
        if (res_ctrl_i) begin
          redirect_pc_d     = actual_npc;
          redirect_taken_d  = res_taken_i;
          redirect_ntaken_d = ~res_taken_i;
          expect_pc_d       = actual_npc;
        end else begin
          // False BTB hit: a non-control instruction always falls through.
          redirect_pc_d    = pc_plus4;
          redirect_nonbr_d = 1'b1;
          expect_pc_d      = pc_plus4;
        end
        state_d = e_wait;
      end else begin
        state_d     = e_run;
        enq_attempt = res_ctrl_i;
      end
    end
  end

  // A full queue can still accept if the head is popped in the same cycle.
  assign enq_v = enq_attempt & (~fifo_full | fb_if.attaboy_yumi_i);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (enq_attempt && fifo_full && !fb_if.attaboy_yumi_i && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + drop_cnt_width_p'(1);
    end
  end

  always_comb begin
    enq_entry                 = '0;
    enq_entry.pc              = actual_npc;
    enq_entry.br_metadata_fwd = res_br_metadata_fwd_i;
    enq_entry.taken           = res_taken_i;
    enq_entry.ntaken          = ~res_taken_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q           <= e_run;
      expect_pc_q       <= '0;
      redirect_v_q      <= 1'b0;
      redirect_pc_q     <= '0;
      redirect_br_v_q   <= 1'b0;
      redirect_md_q     <= '0;
      redirect_taken_q  <= 1'b0;
      redirect_ntaken_q <= 1'b0;
      redirect_nonbr_q  <= 1'b0;
      drop_cnt_q        <= '0;
    end else begin
      state_q           <= state_d;
      expect_pc_q       <= expect_pc_d;
      redirect_v_q      <= redirect_v_d;
      redirect_pc_q     <= redirect_pc_d;
      redirect_br_v_q   <= redirect_br_v_d;
      redirect_md_q     <= redirect_md_d;
      redirect_taken_q  <= redirect_taken_d;
      redirect_ntaken_q <= redirect_ntaken_d;
      redirect_nonbr_q  <= redirect_nonbr_d;
      drop_cnt_q        <= drop_cnt_d;
    end
  end

  bp_be_attaboy_fifo #(
    .els_p   (attaboy_fifo_els_p),
    .width_p (entry_width_lp)
  ) attaboy_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (enq_v),
    .data_i    (enq_entry),
    .full_o    (fifo_full),
    .v_o       (fifo_v),
    .data_o    (head_bits),
    .yumi_i    (fb_if.attaboy_yumi_i)
  );

  assign head_entry = bp_be_attaboy_entry_s'(head_bits);

  assign fb_if.redirect_v_o               = redirect_v_q;
  assign fb_if.redirect_pc_o              = redirect_pc_q;
  assign fb_if.redirect_br_v_o            = redirect_br_v_q;
  assign fb_if.redirect_br_metadata_fwd_o = redirect_md_q;
  assign fb_if.redirect_br_taken_o        = redirect_taken_q;
  assign fb_if.redirect_br_ntaken_o       = redirect_ntaken_q;
  assign fb_if.redirect_br_nonbr_o        = redirect_nonbr_q;

  assign fb_if.attaboy_v_o               = fifo_v;
  assign fb_if.attaboy_pc_o              = head_entry.pc;
  assign fb_if.attaboy_br_metadata_fwd_o = head_entry.br_metadata_fwd;
  assign fb_if.attaboy_taken_o           = head_entry.taken;
  assign fb_if.attaboy_ntaken_o          = head_entry.ntaken;
  assign fb_if.attaboy_drop_cnt_o        = drop_cnt_q;

endmodule
